inst_decode_stage: RTL

- Registered MIPS instruction-decode stage. It replaces the combinational field splitter between fetch and register-read.
- Accepts one instruction word plus its PC over a valid/ready handshake.
- Classifies the word as R, I or J type and splits every field, with fields that do not apply forced to zero.
- Extends the immediate according to the opcode, computes branch and jump targets, and presents the result through a 2-entry skid buffer with flush support.

---
 rtl/mips_isa_pkg.sv | 36 +++
 rtl/inst_field_decode.sv | 62 ++++++
 rtl/inst_decode_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and the decoded-field struct shared by the decode stage.
// The struct holds the fixed-width fields; PC-width values are carried beside it.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    TYPE_R = 2'd0,
    TYPE_I = 2'd1,
    TYPE_J = 2'd2
  } inst_type_e;

  typedef struct packed {
    logic [5:0]  opcode;
    inst_type_e  itype;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] jaddr;
  } dec_fields_t;

  function automatic inst_type_e classify(input logic [5:0] op);
    if (op == OP_RTYPE) return TYPE_R;
    if (op == OP_J || op == OP_JAL) return TYPE_J;
    return TYPE_I;
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational field splitter: instruction word + PC -> decoded fields,
// extended immediate and branch/jump target. Inapplicable fields are zero.
module inst_field_decode
  import mips_isa_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output dec_fields_t     fields,
  output logic [PC_W-1:0] imm,
  output logic [PC_W-1:0] target
);

  logic [5:0]      op;
  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] sext;
  logic [PC_W-1:0] zext;
  logic [PC_W-1:0] lui_imm;

  assign op      = instr[31:26];
  assign pc4     = pc + PC_W'(4);
  assign sext    = PC_W'(signed'(instr[15:0]));
  assign zext    = PC_W'(instr[15:0]);
  assign lui_imm = PC_W'(signed'({instr[15:0], 16'h0000}));

  always_comb begin
    fields        = '0;
    imm           = '0;
    target        = '0;
    fields.opcode = op;
    fields.itype  = classify(op);
    case (fields.itype)
      TYPE_R: begin
        fields.rs    = instr[25:21];
        fields.rt    = instr[20:16];
        fields.rd    = instr[15:11];
        fields.shamt = instr[10:6];
        fields.funct = instr[5:0];
      end
      TYPE_I: begin
        fields.rs = instr[25:21];
        fields.rt = instr[20:16];
        if (op == OP_LUI)
          imm = lui_imm;
        else if (ZEXT_LOGIC && (op == OP_ANDI || op == OP_ORI || op == OP_XORI))
          imm = zext;
        else
          imm = sext;
        // Branch offset always uses the sign-extended field, whatever imm shows.
        target = pc4 + (sext << 2);
      end
      TYPE_J: begin
        fields.jaddr = instr[25:0];
        target       = {pc4[PC_W-1:28], instr[25:0], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered MIPS decode stage: field decode on the input side, then a
// main register plus a skid register giving full throughput with backpressure.
module inst_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int TAG_W      = 4,
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [1:0]        out_type,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [PC_W-1:0]   out_imm,
  output logic [25:0]       out_jaddr,
  output logic [PC_W-1:0]   out_target,
  output logic [PC_W-1:0]   out_pc,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    dec_fields_t      f;
    logic [PC_W-1:0]  imm;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t dec_entry;
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   consume;

  inst_field_decode #(
    .PC_W       (PC_W),
    .ZEXT_LOGIC (ZEXT_LOGIC)
  ) u_decode (
    .instr  (in_instr),
    .pc     (in_pc),
    .fields (dec_entry.f),
    .imm    (dec_entry.imm),
    .target (dec_entry.target)
  );

  assign dec_entry.pc  = in_pc;
  assign dec_entry.tag = in_tag;

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; a producer holds valid and its data steady until that edge.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign consume  = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume) begin
      // Skid is only ever full while in_ready is low, so accept and a skid
      // refill never coincide here.
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= dec_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_q     <= dec_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec_entry;
        skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid  = main_valid;
  assign out_opcode = main_q.f.opcode;
  assign out_type   = main_q.f.itype;
  assign out_rs     = main_q.f.rs;
  assign out_rt     = main_q.f.rt;
  assign out_rd     = main_q.f.rd;
  assign out_shamt  = main_q.f.shamt;
  assign out_funct  = main_q.f.funct;
  assign out_imm    = main_q.imm;
  assign out_jaddr  = main_q.f.jaddr;
  assign out_target = main_q.target;
  assign out_pc     = main_q.pc;
  assign out_tag    = main_q.tag;

endmodule
